serial_frame_deser: RTL and testbench

Serial-to-parallel frame deserializer that consumes the single-bit stream produced by the team's registered-bit (DFF) capture stage. It hunts for a fixed sync pattern, then collects the following WORD_W bits into a parallel word presented on a valid/ready output with a one-deep holding register. Words that arrive while the holding register is full are dropped and flagged.

---
 rtl/serial_frame_deser.sv | 81 ++++++++
 tb/tb_serial_frame_deser.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser.sv
// serial_frame_deser: hunts a sync pattern in a qualified serial stream and deserializes the following WORD_W bits
// Ports: c clock, r sync active-low reset, d/d_en qualified serial bit,
//        out_data/out_valid/out_ready one-deep word handshake,
//        sync_seen one-cycle detection pulse, overrun sticky word-dropped flag
module serial_frame_deser #(
  parameter int SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC = 4'b1001,
  parameter int WORD_W = 8
) (
  input  logic              c,
  input  logic              r,
  input  logic              d,
  input  logic              d_en,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              sync_seen,
  output logic              overrun
);
  localparam int FW = $clog2(SYNC_LEN + 1);
  localparam int CW = $clog2(WORD_W + 1);
  typedef enum logic {HUNT, CAPTURE} state_t;
  state_t            r_state;
  logic [SYNC_LEN-1:0] r_win;
  logic [FW-1:0]     r_fill;
  logic [CW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_sh;
  logic [SYNC_LEN-1:0] w_win;
  logic [FW-1:0]     w_fill;
  logic [WORD_W-1:0] w_word;
  logic              w_match;
  logic              w_done;
  logic              w_load;
  // Truncating casts keep the newest bits, so SYNC_LEN/WORD_W of 1 need no special case
  assign w_win   = SYNC_LEN'({r_win, d});
  assign w_word  = WORD_W'({r_sh, d});
  assign w_fill  = (r_fill == FW'(SYNC_LEN)) ? r_fill : r_fill + FW'(1);
  assign w_match = (w_win == SYNC) && (w_fill == FW'(SYNC_LEN));
  assign w_done  = d_en && (r_state == CAPTURE) && (r_cnt == CW'(WORD_W - 1));
  assign w_load  = w_done && (!out_valid || out_ready);
  always_ff @(posedge c) begin
    if (!r) begin
      r_state   <= HUNT;
      r_win     <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_sh      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sync_seen <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync_seen <= 1'b0;
      if (d_en && r_state == HUNT) begin
        r_win  <= w_win;
        r_fill <= w_fill;
        if (w_match) begin
          r_state   <= CAPTURE;
          r_cnt     <= '0;
          sync_seen <= 1'b1;
        end
      end else if (d_en) begin
        r_sh  <= w_word;
        r_cnt <= r_cnt + CW'(1);
        // Payload bits must never seed the next sync search
        if (w_done) begin
          r_state <= HUNT;
          r_win   <= '0;
          r_fill  <= '0;
        end
      end
      if (w_done && !w_load) overrun <= 1'b1;
      if (w_load) begin
        out_data  <= w_word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_deser.sv
// tb_serial_frame_deser: directed and random checks of serial_frame_deser against a bit-list reference model
module tb_serial_frame_deser;
  localparam logic [3:0] SYNC = 4'b1001;
  logic c = 1'b0;
  logic r = 1'b0;
  logic d = 1'b0;
  logic d_en = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] out_data;
  logic out_valid;
  logic sync_seen;
  logic overrun;
  int n_chk = 0;
  int n_fail = 0;
  bit hist[$];
  bit m_hunt = 1'b1;
  int m_pay = 0;
  int m_n = 0;
  logic [7:0] m_data = '0;
  logic m_valid = 1'b0;
  logic m_sync = 1'b0;
  logic m_ovr = 1'b0;

  serial_frame_deser #(.SYNC_LEN(4), .SYNC(SYNC), .WORD_W(8)) dut (
    .c(c), .r(r), .d(d), .d_en(d_en), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .sync_seen(sync_seen), .overrun(overrun)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: hunt keeps the last SYNC_LEN qualified bits as a list; capture accumulates arithmetically
  task automatic model(input bit rv, input bit dv, input bit ev, input bit rdy);
    bit done = 0;
    int v = 0;
    if (!rv) begin
      hist.delete(); m_hunt = 1; m_pay = 0; m_n = 0;
      m_data = '0; m_valid = 0; m_sync = 0; m_ovr = 0;
      return;
    end
    m_sync = 0;
    if (ev && m_hunt) begin
      hist.push_back(dv);
      if (hist.size() > 4) void'(hist.pop_front());
      foreach (hist[i]) v = v * 2 + int'(hist[i]);
      if (hist.size() == 4 && v == int'(SYNC)) begin
        m_hunt = 0; m_pay = 0; m_n = 0; m_sync = 1;
      end
    end else if (ev) begin
      m_pay = m_pay * 2 + int'(dv);
      m_n++;
      if (m_n == 8) begin
        done = 1; m_hunt = 1; hist.delete();
      end
    end
    if (done && (!m_valid || rdy)) begin
      m_data = 8'(m_pay); m_valid = 1;
    end else if (done) m_ovr = 1;
    else if (m_valid && rdy) m_valid = 0;
  endtask

  task automatic step(input bit rv, input bit dv, input bit ev, input bit rdy);
    @(negedge c);
    r = rv; d = dv; d_en = ev; out_ready = rdy;
    @(posedge c);
    model(rv, dv, ev, rdy);
    #1;
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("sync_seen", 32'(sync_seen), 32'(m_sync));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic send(input logic [31:0] bits, input int n, input bit rdy, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap) step(1, 1'($urandom_range(0, 1)), 0, rdy);
      step(1, bits[i], 1, rdy);
    end
  endtask

  initial begin
    // Reset held for two edges with random stimulus
    for (int i = 0; i < 2; i++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    send(3'b100, 3, 1, 0);
    chk("rst_nosync", 32'(sync_seen), 32'h0);
    // Basic frame (completes the sync with the 4th bit)
    send(1'b1, 1, 1, 0);
    chk("basic_sync", 32'(sync_seen), 32'h1);
    send(8'hA5, 8, 1, 0);
    chk("basic_data", 32'(out_data), 32'hA5);
    chk("basic_valid", 32'(out_valid), 32'h1);
    step(1, 0, 0, 1);
    chk("basic_consumed", 32'(out_valid), 32'h0);
    // Sliding hunt
    send(4'b1100, 4, 1, 0);
    chk("slide_nosync", 32'(sync_seen), 32'h0);
    send(1'b1, 1, 1, 0);
    chk("slide_sync", 32'(sync_seen), 32'h1);
    send(8'h3C, 8, 1, 0);
    chk("slide_data", 32'(out_data), 32'h3C);
    step(1, 0, 0, 1);
    // Backpressure and overrun
    send({SYNC, 8'hA5}, 12, 0, 0);
    chk("bp_data1", 32'(out_data), 32'hA5);
    chk("bp_ovr1", 32'(overrun), 32'h0);
    send({SYNC, 8'h3C}, 12, 0, 0);
    chk("bp_data2", 32'(out_data), 32'hA5);
    chk("bp_ovr2", 32'(overrun), 32'h1);
    step(1, 0, 0, 1);
    chk("bp_drain", 32'(out_valid), 32'h0);
    chk("bp_sticky", 32'(overrun), 32'h1);
    // Qualifier gaps
    step(0, 0, 0, 1);
    send({SYNC, 8'hA5}, 12, 1, 1);
    chk("gap_data", 32'(out_data), 32'hA5);
    chk("gap_valid", 32'(out_valid), 32'h1);
    step(1, 0, 0, 1);
    // Mid-frame reset
    send({SYNC, 5'b10110}, 9, 1, 0);
    step(0, 1, 1, 1);
    send({SYNC, 8'h5A}, 12, 1, 0);
    chk("mid_data", 32'(out_data), 32'h5A);
    chk("mid_valid", 32'(out_valid), 32'h1);
    chk("mid_ovr", 32'(overrun), 32'h0);
    // Random traffic with embedded sync patterns
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) send(SYNC, 4, 1'($urandom_range(0, 1)), 0);
      step($urandom_range(0, 79) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
